forward_mux_stage: RTL and testbench
====================================

# forward_mux_stage

Parametrised, registered N-way operand selector for the pipelined CPU datapath, the successor to the fixed 2-input 32-bit combinational multiplexer. Each of CH channels (e.g. rs and rt operands) picks one of N sources (register file, EX/MEM, MEM/WB, ...) per cycle. The result is captured in a pipeline register that supports stall (hold) and flush (bubble). It sits at the ID/EX or EX boundary, where forwarding results must be registered alongside a valid bit.

## Interface
- `W`, 32: data width per source
- `N`, 3: sources per channel (≥2)
- `CH`, 2: independent channels
- `MODE`, 0: 0 = binary select, 1 = priority one-hot forwarding select
- `SELW` (derived, not overridable): MODE 0 → max(1, clog2(N)); MODE 1 → N
- Ports:
  - `clk`  in  1  rising-edge clock
  - `reset`  in  1  synchronous, active-high; clears all state
  - `stall`  in  1  hold the register contents
  - `flush`  in  1  load a bubble (valid 0, data 0)
  - `in_valid`  in  1  the incoming instruction slot is valid
  - `sel`  in  CH*SELW  channel c select at [c*SELW +: SELW]
  - `in_data`  in  CH*N*W  channel c, source i at [(c*N+i)*W +: W]
  - `out_valid`  out  1  registered valid
  - `out_data`  out  CH*W  registered selected data; channel c at [c*W +: W]
  - `out_fwd`  out  CH  registered: channel c took a source other than 0
  - `out_sel_err`  out  1  registered: some channel had an out-of-range binary select

## Operation
- Combinational select per channel, computed every cycle:
  - MODE 0: source index = sel_c. If sel_c ≥ N, use source 0 and flag an error for that channel.
  - MODE 1: bit 0 of sel_c is ignored. The lowest set index among bits 1..N-1 wins. If none are set, use source 0. Errors never occur in this mode.
- Register update priority, evaluated at each rising edge of `clk`:
  1. `reset`: all outputs cleared to 0.
  2. `flush`: `out_valid` = 0, `out_data` = 0, `out_fwd` = 0, `out_sel_err` = 0. Flush beats stall.
  3. `stall`: every output holds its previous value.
  4. Otherwise, load: `out_valid` ← `in_valid`, `out_data`/`out_fwd` ← selected values, `out_sel_err` ← OR of the per-channel errors.
- Data is loaded even when `in_valid` = 0; downstream must qualify data with `out_valid`.
- `out_fwd[c]` = 1 exactly when the resolved index for channel c is nonzero. An out-of-range fallback to source 0 gives `out_fwd` = 0.
- Channels are fully independent; there is no cross-channel interaction apart from the shared stall/flush/valid controls.

## Timing
- Latency is 1 cycle from `sel`/`in_data` to `out_*`. There are no combinational paths from inputs to outputs.
- Reset value of every output is 0. Reset takes effect at the first rising edge while `reset` = 1, and this holds even in the middle of a stall.
- Stall may last any number of cycles. Outputs stay bit-stable throughout, regardless of changes on the inputs.
- The cycle after `stall` deasserts loads the inputs current at that edge; values that were present during the stall are not replayed.
- Asserting flush and stall together inserts a bubble. Flush without stall inserts a bubble for one cycle.

## Structure
- The shared package `cpu_pkg` holds:
  - the MODE constants `FWD_MODE_BIN` = 0 and `FWD_MODE_PRIO` = 1;
  - the function `fwd_selw(N, MODE)` used to derive `SELW`.
- Sub-module `fwd_sel_comb` (parameters `W`, `N`, `MODE`): a single-channel combinational resolver that outputs the index, data, fwd flag and error. It is instantiated CH times with a generate loop. The top level owns only the register and the control priority.

## Test plan
- Binary select, W=32, N=3, CH=2: channel 0 sources = 0x11, 0x22, 0x33; channel 1 sources = 0xA1, 0xA2, 0xA3. Set sel = {2,1} with in_valid = 1. Next cycle: out_data = {0x33, 0xA2}… per channel (ch0 = 0x33, ch1 = 0xA2), out_fwd = 2'b11, out_valid = 1, out_sel_err = 0.
- Out-of-range, MODE 0, N=3: sel_ch0 = 3 with source 0 = 0xDEAD. Next cycle: ch0 = 0xDEAD, out_fwd[0] = 0, out_sel_err = 1. The following clean cycle gives out_sel_err = 0.
- Stall hold: load 0x22, then hold stall = 1 for 4 cycles while the inputs change randomly. Outputs stay 0x22/valid for all 4 cycles. After release, the next edge loads the current inputs.
- Flush vs stall: with stall = 1 and flush = 1 together, next cycle out_valid = 0 and out_data = 0. Flush alone behaves the same. Afterwards a normal load resumes.
- Priority mode, MODE 1, N=3: sel_ch0 = 3'b110 → source 1. sel_ch0 = 3'b100 → source 2. sel_ch0 = 3'b001 → source 0 with out_fwd[0] = 0.
- Reset mid-operation: while stalled with valid data, assert reset for one cycle. All outputs are 0 the next cycle even though stall stays high. After reset deasserts, a load with stall = 0 works normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: forwarding-select modes and the helper that
// sizes a forwarding select field.
package cpu_pkg;

    localparam int FWD_MODE_BIN  = 0;
    localparam int FWD_MODE_PRIO = 1;

    // Binary mode needs an index wide enough for N sources (at least 1 bit);
    // priority mode carries one bit per source.
    function automatic int fwd_selw(input int n, input int mode);
        int w;
        if (mode == FWD_MODE_PRIO) begin
            w = n;
        end else begin
            w = (n > 1) ? $clog2(n) : 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fwd_sel_comb.sv
// Single-channel forwarding resolver: turns a select field into a source index,
// the selected data word, a forwarded flag and an out-of-range error.
module fwd_sel_comb
    import cpu_pkg::*;
#(
    parameter int W    = 32,
    parameter int N    = 3,
    parameter int MODE = FWD_MODE_BIN,
    localparam int SELW = fwd_selw(N, MODE),
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  data,
    output logic [IW-1:0]   idx,
    output logic [W-1:0]    out,
    output logic            fwd,
    output logic            err
);

    if (MODE == FWD_MODE_PRIO) begin : g_prio
        // Bit 0 names the register file, which is the fallback anyway.
        logic sel0_unused;
        assign sel0_unused = sel[0];

        always_comb begin
            idx = '0;
            err = 1'b0;
            // Walk downward so the lowest set bit is the last one written.
            for (int i = N - 1; i >= 1; i--) begin
                if (sel[i]) begin
                    idx = IW'(i);
                end
            end
        end
    end else begin : g_bin
        always_comb begin
            idx = '0;
            err = 1'b0;
            if (32'(sel) >= N) begin
                err = 1'b1;
            end else begin
                idx = IW'(sel);
            end
        end
    end

    always_comb begin
        out = data[32'(idx)*W +: W];
        fwd = (idx != '0);
    end

endmodule

// File: rtl/forward_mux_stage.sv
// Registered N-way operand selector: CH independent resolvers feeding one
// pipeline register with reset > flush > stall > load priority.
module forward_mux_stage
    import cpu_pkg::*;
#(
    parameter int W    = 32,
    parameter int N    = 3,
    parameter int CH   = 2,
    parameter int MODE = FWD_MODE_BIN,
    localparam int SELW = fwd_selw(N, MODE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [CH*SELW-1:0] sel,
    input  logic [CH*N*W-1:0]  in_data,
    output logic               out_valid,
    output logic [CH*W-1:0]    out_data,
    output logic [CH-1:0]      out_fwd,
    output logic               out_sel_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [CH*W-1:0] sel_data;
    logic [CH-1:0]   sel_fwd;
    logic [CH-1:0]   sel_err;

    logic            valid_reg, valid_next;
    logic [CH*W-1:0] data_reg,  data_next;
    logic [CH-1:0]   fwd_reg,   fwd_next;
    logic            err_reg,   err_next;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [IW-1:0] idx_unused;

        fwd_sel_comb #(
            .W    (W),
            .N    (N),
            .MODE (MODE)
        ) u_sel (
            .sel  (sel[gi*SELW +: SELW]),
            .data (in_data[gi*N*W +: N*W]),
            .idx  (idx_unused),
            .out  (sel_data[gi*W +: W]),
            .fwd  (sel_fwd[gi]),
            .err  (sel_err[gi])
        );
    end

    always_comb begin
        valid_next = valid_reg;
        data_next  = data_reg;
        fwd_next   = fwd_reg;
        err_next   = err_reg;
        if (flush) begin
            valid_next = 1'b0;
            data_next  = '0;
            fwd_next   = '0;
            err_next   = 1'b0;
        end else if (!stall) begin
            // Data loads regardless of in_valid; consumers qualify with out_valid.
            valid_next = in_valid;
            data_next  = sel_data;
            fwd_next   = sel_fwd;
            err_next   = |sel_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            fwd_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
            fwd_reg   <= fwd_next;
            err_reg   <= err_next;
        end
    end

    assign out_valid   = valid_reg;
    assign out_data    = data_reg;
    assign out_fwd     = fwd_reg;
    assign out_sel_err = err_reg;

endmodule

// File: tb/tb_forward_mux_stage.sv
// Directed bench for forward_mux_stage: a binary-select and a priority-select
// instance share controls and data; expected values are hand-computed constants.
module tb_forward_mux_stage;
    import cpu_pkg::*;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int CH = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [CH*2-1:0]  sel_bin = '0;
    logic [CH*3-1:0]  sel_prio = '0;
    logic [CH*N*W-1:0] in_data = '0;

    logic             b_valid, p_valid;
    logic [CH*W-1:0]  b_data, p_data;
    logic [CH-1:0]    b_fwd, p_fwd;
    logic             b_err, p_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    forward_mux_stage #(.W(W), .N(N), .CH(CH), .MODE(FWD_MODE_BIN)) u_bin (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .sel         (sel_bin),
        .in_data     (in_data),
        .out_valid   (b_valid),
        .out_data    (b_data),
        .out_fwd     (b_fwd),
        .out_sel_err (b_err)
    );

    forward_mux_stage #(.W(W), .N(N), .CH(CH), .MODE(FWD_MODE_PRIO)) u_prio (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .sel         (sel_prio),
        .in_data     (in_data),
        .out_valid   (p_valid),
        .out_data    (p_data),
        .out_fwd     (p_fwd),
        .out_sel_err (p_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sources(input logic [W-1:0] c0s0);
        in_data = {32'hA3, 32'hA2, 32'hA1, 32'h33, 32'h22, c0s0};
    endtask

    initial begin
        set_sources(32'h11);
        step();
        step();
        chk("reset_valid", 64'(b_valid), 64'd0);
        chk("reset_data",  64'(b_data),  64'd0);
        chk("reset_fwd",   64'({b_fwd, b_err}), 64'd0);
        reset = 1'b0;

        // Binary select: ch0 <- src2, ch1 <- src1.
        in_valid = 1'b1;
        sel_bin  = {2'd1, 2'd2};
        step();
        chk("bin_data",  64'(b_data), {32'hA2, 32'h33});
        chk("bin_fwd",   64'(b_fwd),  64'b11);
        chk("bin_valid", 64'({b_valid, b_err}), 64'b10);

        // Out-of-range select falls back to source 0 and raises the error.
        set_sources(32'hDEAD);
        sel_bin = {2'd0, 2'd3};
        step();
        chk("oor_data", 64'(b_data), {32'hA1, 32'hDEAD});
        chk("oor_fwd",  64'(b_fwd),  64'b00);
        chk("oor_err",  64'(b_err),  64'd1);
        sel_bin = {2'd0, 2'd0};
        step();
        chk("oor_clear", 64'(b_err), 64'd0);

        // Stall holds through input churn.
        set_sources(32'h11);
        sel_bin = {2'd0, 2'd1};
        step();
        chk("stall_load", 64'(b_data), {32'hA1, 32'h22});
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            sel_bin  = 4'($urandom);
            in_valid = 1'($urandom);
            step();
            chk($sformatf("stall_hold%0d", i), {31'd0, b_valid, b_data[31:0]}, {31'd0, 1'b1, 32'h22});
        end
        stall    = 1'b0;
        in_valid = 1'b1;
        set_sources(32'h11);
        sel_bin  = {2'd2, 2'd2};
        step();
        chk("stall_release", 64'(b_data), {32'hA3, 32'h33});

        // Flush with stall, flush alone, then a normal load.
        stall = 1'b1;
        flush = 1'b1;
        step();
        chk("flush_stall", {b_valid, b_fwd, b_err, b_data}, '0);
        stall = 1'b0;
        step();
        chk("flush_only", {b_valid, b_fwd, b_err, b_data}, '0);
        flush = 1'b0;
        sel_bin = {2'd1, 2'd0};
        step();
        chk("flush_resume", {30'd0, b_valid, b_fwd, b_data}, {30'd0, 1'b1, 2'b10, 32'hA2, 32'h11});

        // Priority one-hot: lowest set bit among 1..N-1, bit 0 ignored.
        sel_prio = {3'b001, 3'b110};
        step();
        chk("prio_110",  64'(p_data), {32'hA1, 32'h22});
        chk("prio_fwd1", 64'({p_fwd, p_err}), 64'b010);
        sel_prio = {3'b010, 3'b100};
        step();
        chk("prio_100",  64'(p_data), {32'hA2, 32'h33});
        chk("prio_fwd2", 64'(p_fwd), 64'b11);
        sel_prio = {3'b000, 3'b001};
        step();
        chk("prio_001",  64'(p_data), {32'hA1, 32'h11});
        chk("prio_fwd3", 64'({p_fwd, p_err}), 64'b000);

        // Reset in the middle of a stall.
        sel_bin = {2'd2, 2'd1};
        step();
        stall = 1'b1;
        step();
        chk("pre_reset", 64'({b_valid, b_fwd}), 64'b111);
        reset = 1'b1;
        step();
        chk("mid_reset", {b_valid, b_fwd, b_err, b_data}, '0);
        chk("mid_reset_prio", {p_valid, p_fwd, p_err, p_data}, '0);
        reset = 1'b0;
        stall = 1'b0;
        step();
        chk("post_reset", {30'd0, b_valid, b_fwd, b_data}, {30'd0, 1'b1, 2'b11, 32'hA3, 32'h22});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
